// File: rtl/clock_pkg.sv
// Shared encodings and field limits for the calendar set-mode sequencer.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SET_MONTH = 3'd1,
    ST_SET_DAY   = 3'd2,
    ST_SET_HOUR  = 3'd3,
    ST_SET_MIN   = 3'd4
  } state_e;

  localparam int MONTH_MAX = 4;
  localparam int DAY_MAX   = 30;
  localparam int HOUR_MAX  = 23;
  localparam int MIN_MAX   = 59;

endpackage

// File: rtl/clock_set_controller_bcd_field_inc.sv
// Combinational two-digit BCD increment; values at or above MAX (or with a
// non-decimal digit) wrap to 00.
module bcd_field_inc #(
  parameter int MAX = 59
) (
  input  logic [3:0] tens_i,
  input  logic [3:0] units_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  logic [7:0] value;

  assign value = {4'd0, tens_i} * 8'd10 + {4'd0, units_i};

  always_comb begin
    tens_o  = tens_i;
    units_o = units_i + 4'd1;
    if ((tens_i > 4'd9) || (units_i > 4'd9) || (value >= 8'(MAX))) begin
      tens_o  = 4'd0;
      units_o = 4'd0;
    end else if (units_i == 4'd9) begin
      tens_o  = tens_i + 4'd1;
      units_o = 4'd0;
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// Second-tick prescaler plus button-driven set-mode FSM that edits and loads
// month/day/hour/minute into the calendar counter.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int PRESC_W  = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_minbcd1,
  input  logic [3:0] cur_minbcd0,
  input  logic [3:0] cur_hourbcd1,
  input  logic [3:0] cur_hourbcd0,
  input  logic [3:0] cur_daybcd1,
  input  logic [3:0] cur_daybcd0,
  input  logic [3:0] cur_monthbcd,
  output logic       count_enable,
  output logic       load,
  output logic [3:0] set_minbcd1,
  output logic [3:0] set_minbcd0,
  output logic [3:0] set_hourbcd1,
  output logic [3:0] set_hourbcd0,
  output logic [3:0] set_daybcd1,
  output logic [3:0] set_daybcd0,
  output logic [3:0] set_monthbcd,
  output logic [2:0] edit_field
);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               ce_q, ce_d;
  logic               load_q, load_d;
  logic               btn_mode_q, btn_inc_q;
  logic [3:0]         month_q, month_d;
  logic [3:0]         day_t_q, day_t_d, day_u_q, day_u_d;
  logic [3:0]         hour_t_q, hour_t_d, hour_u_q, hour_u_d;
  logic [3:0]         min_t_q, min_t_d, min_u_q, min_u_d;

  logic       edge_mode, edge_inc;
  logic [3:0] month_t_inc, month_u_inc;
  logic [3:0] day_t_inc, day_u_inc, hour_t_inc, hour_u_inc, min_t_inc, min_u_inc;

  assign edge_mode = btn_mode & ~btn_mode_q;
  assign edge_inc  = btn_inc & ~btn_inc_q;

  bcd_field_inc #(.MAX(MONTH_MAX)) u_month_inc (
    .tens_i(4'd0), .units_i(month_q), .tens_o(month_t_inc), .units_o(month_u_inc));
  bcd_field_inc #(.MAX(DAY_MAX)) u_day_inc (
    .tens_i(day_t_q), .units_i(day_u_q), .tens_o(day_t_inc), .units_o(day_u_inc));
  bcd_field_inc #(.MAX(HOUR_MAX)) u_hour_inc (
    .tens_i(hour_t_q), .units_i(hour_u_q), .tens_o(hour_t_inc), .units_o(hour_u_inc));
  bcd_field_inc #(.MAX(MIN_MAX)) u_min_inc (
    .tens_i(min_t_q), .units_i(min_u_q), .tens_o(min_t_inc), .units_o(min_u_inc));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      presc_q    <= '0;
      ce_q       <= 1'b0;
      load_q     <= 1'b0;
      btn_mode_q <= 1'b1;
      btn_inc_q  <= 1'b1;
      month_q    <= '0;
      day_t_q    <= '0;
      day_u_q    <= '0;
      hour_t_q   <= '0;
      hour_u_q   <= '0;
      min_t_q    <= '0;
      min_u_q    <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      ce_q       <= ce_d;
      load_q     <= load_d;
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
      month_q    <= month_d;
      day_t_q    <= day_t_d;
      day_u_q    <= day_u_d;
      hour_t_q   <= hour_t_d;
      hour_u_q   <= hour_u_d;
      min_t_q    <= min_t_d;
      min_u_q    <= min_u_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = '0;
    ce_d     = 1'b0;
    load_d   = 1'b0;
    month_d  = month_q;
    day_t_d  = day_t_q;
    day_u_d  = day_u_q;
    hour_t_d = hour_t_q;
    hour_u_d = hour_u_q;
    min_t_d  = min_t_q;
    min_u_d  = min_u_q;
    unique case (state_q)
      ST_RUN: begin
        if (edge_mode) begin
          state_d  = ST_SET_MONTH;
          month_d  = cur_monthbcd;
          day_t_d  = cur_daybcd1;
          day_u_d  = cur_daybcd0;
          hour_t_d = cur_hourbcd1;
          hour_u_d = cur_hourbcd0;
          min_t_d  = cur_minbcd1;
          min_u_d  = cur_minbcd0;
        end else if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
          ce_d = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_SET_MONTH: begin
        if (edge_mode) state_d = ST_SET_DAY;
        // The month field is a single digit; a nonzero tens result cannot occur.
        else if (edge_inc) month_d = (month_t_inc == 4'd0) ? month_u_inc : 4'd0;
      end
      ST_SET_DAY: begin
        if (edge_mode) state_d = ST_SET_HOUR;
        else if (edge_inc) begin
          day_t_d = day_t_inc;
          day_u_d = day_u_inc;
        end
      end
      ST_SET_HOUR: begin
        if (edge_mode) state_d = ST_SET_MIN;
        else if (edge_inc) begin
          hour_t_d = hour_t_inc;
          hour_u_d = hour_u_inc;
        end
      end
      ST_SET_MIN: begin
        if (edge_mode) begin
          state_d = ST_RUN;
          load_d  = 1'b1;
        end else if (edge_inc) begin
          min_t_d = min_t_inc;
          min_u_d = min_u_inc;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign count_enable = ce_q;
  assign load         = load_q;
  assign edit_field   = state_q;
  assign set_monthbcd = month_q;
  assign set_daybcd1  = day_t_q;
  assign set_daybcd0  = day_u_q;
  assign set_hourbcd1 = hour_t_q;
  assign set_hourbcd0 = hour_u_q;
  assign set_minbcd1  = min_t_q;
  assign set_minbcd0  = min_u_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller against an integer-level
// model of the set-mode rules.
module tb_clock_set_controller;

  localparam int TICK_DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] cur_minbcd1, cur_minbcd0, cur_hourbcd1, cur_hourbcd0;
  logic [3:0] cur_daybcd1, cur_daybcd0, cur_monthbcd;
  logic       count_enable, load;
  logic [3:0] set_minbcd1, set_minbcd0, set_hourbcd1, set_hourbcd0;
  logic [3:0] set_daybcd1, set_daybcd0, set_monthbcd;
  logic [2:0] edit_field;
  logic [27:0] got_bus;

  int checks = 0;
  int errors = 0;

  // Live counter values (month, day, hour, minute) as plain integers.
  int c_val[4];
  // Model: edit values, mode (0 run, 1..4 fields), cycles since run start.
  int m_val[4];
  int m_state = 0;
  int m_run = 0;
  bit pm = 1'b1, pi = 1'b1;
  bit m_ce = 1'b0, m_load = 1'b0;

  always #5 clock = ~clock;

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int fmax(input int f);
    case (f)
      0: return 4;
      1: return 30;
      2: return 23;
      default: return 59;
    endcase
  endfunction

  function automatic logic [27:0] exp_bus();
    return {4'(m_val[0]), bcd2(m_val[1]), bcd2(m_val[2]), bcd2(m_val[3])};
  endfunction

  assign cur_monthbcd = 4'(c_val[0]);
  assign {cur_daybcd1, cur_daybcd0}   = bcd2(c_val[1]);
  assign {cur_hourbcd1, cur_hourbcd0} = bcd2(c_val[2]);
  assign {cur_minbcd1, cur_minbcd0}   = bcd2(c_val[3]);
  assign got_bus = {set_monthbcd, set_daybcd1, set_daybcd0, set_hourbcd1,
                    set_hourbcd0, set_minbcd1, set_minbcd0};

  clock_set_controller #(.TICK_DIV(TICK_DIV), .PRESC_W(3)) dut (
    .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_minbcd1(cur_minbcd1), .cur_minbcd0(cur_minbcd0),
    .cur_hourbcd1(cur_hourbcd1), .cur_hourbcd0(cur_hourbcd0),
    .cur_daybcd1(cur_daybcd1), .cur_daybcd0(cur_daybcd0),
    .cur_monthbcd(cur_monthbcd),
    .count_enable(count_enable), .load(load),
    .set_minbcd1(set_minbcd1), .set_minbcd0(set_minbcd0),
    .set_hourbcd1(set_hourbcd1), .set_hourbcd0(set_hourbcd0),
    .set_daybcd1(set_daybcd1), .set_daybcd0(set_daybcd0),
    .set_monthbcd(set_monthbcd), .edit_field(edit_field));

  // Apply the behavioural rules for the inputs now present, then clock once.
  task automatic tick();
    bit em, ei;
    int f;
    em = btn_mode && !pm;
    ei = btn_inc && !pi;
    pm = btn_mode;
    pi = btn_inc;
    m_ce = 1'b0;
    m_load = 1'b0;
    if (reset) begin
      m_state = 0;
      m_run = 0;
      pm = 1'b1;
      pi = 1'b1;
      for (int i = 0; i < 4; i++) m_val[i] = 0;
    end else if (m_state == 0) begin
      if (em) begin
        m_state = 1;
        for (int i = 0; i < 4; i++) m_val[i] = c_val[i];
      end else begin
        m_run++;
        m_ce = (m_run % TICK_DIV) == 0;
      end
    end else if (em) begin
      if (m_state == 4) begin
        m_state = 0;
        m_load = 1'b1;
        m_run = 0;
      end else begin
        m_state++;
      end
    end else if (ei) begin
      f = m_state - 1;
      m_val[f] = (m_val[f] >= fmax(f)) ? 0 : m_val[f] + 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    btn_mode = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if (edit_field !== 3'd0 || count_enable !== 1'b0 || load !== 1'b0 || got_bus !== 28'd0) begin
      errors++;
      $display("FAIL reset_state field=%0d ce=%b load=%b set=%h, required 0/0/0/0",
               edit_field, count_enable, load, got_bus);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (count_enable !== ((k % 4) == 0) || edit_field !== 3'd0) begin
        errors++;
        $display("FAIL reset_tick cycle %0d ce=%b field=%0d, required ce=%b field=0",
                 k, count_enable, edit_field, (k % 4) == 0);
      end
    end
    btn_mode = 1'b0;
    tick();
  endtask

  task automatic test_enter_set();
    c_val = '{2, 15, 8, 42};
    btn_mode = 1'b1;
    tick();
    checks++;
    if (edit_field !== 3'd1 || got_bus !== 28'h2150842) begin
      errors++;
      $display("FAIL enter_set field=%0d set=%h, required 1 / 2150842", edit_field, got_bus);
    end
    btn_mode = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (count_enable !== 1'b0 || edit_field !== 3'd1) begin
        errors++;
        $display("FAIL frozen cycle %0d ce=%b field=%0d, required 0/1", k, count_enable, edit_field);
      end
    end
  endtask

  task automatic test_field_wrap();
    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < fmax(f) + 2; n++) begin
        btn_inc = 1'b1;
        tick();
        checks++;
        if (got_bus !== exp_bus() || edit_field !== 3'(f + 1) || count_enable !== 1'b0) begin
          errors++;
          $display("FAIL field_inc f=%0d n=%0d set=%h field=%0d ce=%b, required %h/%0d/0",
                   f, n, got_bus, edit_field, count_enable, exp_bus(), f + 1);
        end
        btn_inc = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      if (f != 3) press_mode();
    end
  endtask

  task automatic test_load();
    logic [27:0] final_bus;
    final_bus = exp_bus();
    btn_mode = 1'b1;
    tick();
    checks++;
    if (load !== 1'b1 || edit_field !== 3'd0 || got_bus !== final_bus) begin
      errors++;
      $display("FAIL load_strobe load=%b field=%0d set=%h, required 1/0/%h",
               load, edit_field, got_bus, final_bus);
    end
    btn_mode = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (load !== 1'b0 || count_enable !== (k == 4) || got_bus !== final_bus) begin
        errors++;
        $display("FAIL after_load k=%0d load=%b ce=%b set=%h, required 0/%b/%h",
                 k, load, count_enable, got_bus, (k == 4), final_bus);
      end
    end
  endtask

  task automatic test_simultaneous();
    c_val = '{$urandom_range(0, 4), $urandom_range(0, 30), $urandom_range(0, 23), $urandom_range(0, 59)};
    press_mode();
    press_mode();
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    tick();
    checks++;
    if (edit_field !== 3'd3 || got_bus !== exp_bus() || m_val[1] !== c_val[1]) begin
      errors++;
      $display("FAIL mode_and_inc field=%0d set=%h, required 3/%h", edit_field, got_bus, exp_bus());
    end
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_edit();
    btn_inc = 1'b1;
    tick();
    btn_inc = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (edit_field !== 3'd0 || load !== 1'b0 || got_bus !== 28'd0) begin
      errors++;
      $display("FAIL reset_mid_edit field=%0d load=%b set=%h, required 0/0/0",
               edit_field, load, got_bus);
    end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (load !== 1'b0 || count_enable !== m_ce) begin
        errors++;
        $display("FAIL post_reset k=%0d load=%b ce=%b, required 0/%b", k, load, count_enable, m_ce);
      end
    end
  endtask

  task automatic test_out_of_range();
    c_val = '{7, 15, 27, 75};
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    checks++;
    if (got_bus !== 28'h7152775) begin
      errors++;
      $display("FAIL oor_capture set=%h, required 7152775", got_bus);
    end
    for (int f = 0; f < 4; f++) begin
      tick();
      if (f == 0 || f >= 2) begin
        btn_inc = 1'b1;
        tick();
        btn_inc = 1'b0;
        tick();
        checks++;
        if (got_bus !== exp_bus() || m_val[f] !== 0) begin
          errors++;
          $display("FAIL oor_inc f=%0d set=%h, required %h", f, got_bus, exp_bus());
        end
      end
      btn_mode = 1'b1;
      tick();
      btn_mode = 1'b0;
    end
    checks++;
    if (load !== 1'b1 || got_bus !== exp_bus()) begin
      errors++;
      $display("FAIL oor_load load=%b set=%h, required 1/%h", load, got_bus, exp_bus());
    end
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      c_val = '{$urandom_range(0, 4), $urandom_range(0, 30), $urandom_range(0, 23), $urandom_range(0, 59)};
      for (int k = 0; k < 300; k++) begin
        if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
        if ($urandom_range(0, 2) == 0) btn_inc = ~btn_inc;
        reset = ($urandom_range(0, 199) == 0);
        tick();
        checks++;
        if (count_enable !== m_ce || load !== m_load || edit_field !== 3'(m_state) ||
            got_bus !== exp_bus()) begin
          errors++;
          $display("FAIL random r=%0d k=%0d ce=%b load=%b field=%0d set=%h, required %b/%b/%0d/%h",
                   r, k, count_enable, load, edit_field, got_bus, m_ce, m_load, m_state, exp_bus());
        end
      end
    end
    reset = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    tick();
  endtask

  initial begin
    c_val = '{0, 0, 0, 0};
    m_val = '{0, 0, 0, 0};
    test_reset();
    test_enter_set();
    test_field_wrap();
    test_load();
    test_simultaneous();
    test_reset_mid_edit();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Sequencer for the BCD calendar/time counter (seconds→month chain).
- Divides the system clock into a one-cycle-per-second count enable.
- Runs a button-driven set-mode FSM that lets the user edit month, day, hour and minute.
- Issues a one-cycle load strobe with the edited BCD values.
- Sits between the debounced-button front end and the counter; the counter's enable and load inputs are driven only by this block.

Parameters:
TICK_DIV, 50000000, system clocks per count-enable pulse (≥2; bench uses 4)
PRESC_W, 26, prescaler width; must satisfy 2**PRESC_W ≥ TICK_DIV

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high
btn_mode  input  1  debounced, synchronous level; rising edge advances mode
btn_inc  input  1  debounced, synchronous level; rising edge increments selected field
cur_minbcd1/cur_minbcd0  input  4 each  live minute tens/units from counter
cur_hourbcd1/cur_hourbcd0  input  4 each  live hour tens/units
cur_daybcd1/cur_daybcd0  input  4 each  live day tens/units
cur_monthbcd  input  4  live month index
count_enable  output  1  one-cycle pulse per TICK_DIV clocks, RUN state only
load  output  1  one-cycle strobe; counter loads set_* values and zeroes seconds
set_minbcd1/set_minbcd0, set_hourbcd1/set_hourbcd0, set_daybcd1/set_daybcd0, set_monthbcd  output  4 each  edit registers (BCD)
edit_field  output  3  one-hot-ish field select: 0 RUN, 1 month, 2 day, 3 hour, 4 minute

Behaviour:
- Reset (synchronous, active-high, clock clock): state RUN; prescaler 0; count_enable 0; load 0; all set_* 0; edit_field 0. Button history registers reset to 1, so a button held through reset produces no edge.
- Edge detect: btn_x_q <= btn_x each cycle; edge_x = btn_x & ~btn_x_q. Effects of an edge appear on outputs the cycle after the input rises.
- Prescaler: increments in RUN. At TICK_DIV-1 it wraps to 0 and count_enable = 1 for exactly that next cycle. Held at 0 in every SET state, so the first pulse after returning to RUN comes TICK_DIV clocks after load.
- FSM:
  - RUN -(edge_mode)-> SET_MONTH. On the same edge, capture all cur_* into set_*.
  - SET_MONTH -(edge_mode)-> SET_DAY -> SET_HOUR -> SET_MIN.
  - SET_MIN -(edge_mode)-> RUN with load = 1 for one cycle; set_* hold their values during and after the strobe.
- Increment on edge_inc, selected field only, BCD carry within the field:
  - month: 0..4, 4→0
  - day: 00..30, 30→00; units 9→0 carries into tens
  - hour: 00..23, 23→00; 09→10, 19→20
  - minute: 00..59, 59→00
- edge_inc in RUN is ignored.
- Simultaneous edge_mode and edge_inc: mode wins, inc discarded.
- No count_enable pulses while in any SET state; the counter is frozen.
- Captured out-of-range cur_* values (e.g. hour 27) are not clamped. The next increment saturates the field to its wrap value's successor, i.e. the field is set to 00 (month 0).
- Reset mid-edit: FSM returns to RUN, no load is issued, edits are lost.
- edit_field is a registered encoding of the state.

Decomposition:
- Shared package clock_pkg:
  - state encoding localparams (ST_RUN=0, ST_SET_MONTH=1, ST_SET_DAY=2, ST_SET_HOUR=3, ST_SET_MIN=4)
  - field limits MONTH_MAX=4, DAY_MAX=30, HOUR_MAX=23, MIN_MAX=59
- Sub-module bcd_field_inc: combinational 2-digit BCD increment with a max-value wrap parameter, instantiated once per field. The prescaler and edge detectors stay inline.

Test Plan:
1. Reset with btn_mode held high, then release reset → no state change; edit_field=0; count_enable pulses at cycles 4, 8, 12 (TICK_DIV=4), each one cycle wide.
2. cur = month 2, day 15, hour 08, min 42; pulse btn_mode → edit_field=1, set_* = 2/15/08/42, count_enable stays 0 for ≥20 cycles.
3. In SET_HOUR with hour 23, one btn_inc → set_hour=00. From hour 09, one btn_inc → 10. In SET_DAY, 30→00. In SET_MIN, 59→00. In SET_MONTH, 4→0.
4. From SET_MIN, pulse btn_mode → load=1 for exactly one cycle with final set_* values, edit_field=0; first count_enable appears 4 cycles later.
5. btn_mode and btn_inc rise in the same cycle in SET_DAY → state SET_HOUR, day unchanged.
6. Assert reset while in SET_HOUR → next cycle RUN, load never asserted, set_* = 0.
